// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo: synchronizes raw PS/2 pins, deframes key codes, folds
// E0/F0 prefixes into {ext, rel, code} events and buffers them in a show-ahead FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity check, sets parity_err).
module ps2_scancode_fifo #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2_clk,
  input  logic                     data,
  input  logic                     rd_en,
  output logic [9:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     parity_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // synchronizer and edge detect
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  // frame receiver
  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [TW-1:0]   r_tmo_cnt;
  logic            w_timeout;
  logic            w_frame_ok;
  logic            r_frame_vld;
  logic [7:0]      r_frame_code;

  // prefix decoder
  logic            r_ext, r_rel;
  logic            w_push;
  logic [9:0]      w_push_data;

  // fifo
  logic [9:0]      r_mem [DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic [AW:0]     w_count;
  logic            w_empty, w_full, w_pop, w_wr;
  logic            r_overflow;

`ifdef PS2_PARITY_CHECK_EN
  logic            r_parity;
  logic            w_par_bad;
  logic            r_parity_err;
`endif

  // two-flop synchronizers plus a third clock stage for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_s3 & ~r_clk_s2;
  assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  // frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // frame FSM next state and frame accept decision
  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    w_par_bad   = 1'b0;
`endif
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_bit_idx == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
`ifdef PS2_PARITY_CHECK_EN
          w_par_bad  = ~(^{r_shift, r_parity});
          w_frame_ok = r_dat_s2 & ~w_par_bad;
`else
          w_frame_ok = r_dat_s2;
`endif
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // frame datapath: bit index, shift register, parity capture, timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tmo_cnt <= TW'(0);
`ifdef PS2_PARITY_CHECK_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE || w_fall) begin
        r_tmo_cnt <= TW'(0);
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_fall) begin
        case (r_state)
          ST_IDLE: r_bit_idx <= 3'd0;
          ST_DATA: begin
            r_shift[r_bit_idx] <= r_dat_s2;
            r_bit_idx          <= r_bit_idx + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          ST_PARITY: r_parity <= r_dat_s2;
`endif
          default: ;
        endcase
      end
    end
  end

  // one-cycle accepted-frame strobe with its code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_vld  <= 1'b0;
      r_frame_code <= 8'd0;
    end else begin
      r_frame_vld <= w_frame_ok;
      if (w_frame_ok) r_frame_code <= r_shift;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // sticky parity error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_par_bad) begin
      r_parity_err <= 1'b1;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // prefix flags: E0 sets ext, F0 sets rel, any other code consumes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (r_frame_vld) begin
      if (r_frame_code == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_frame_code == 8'hF0) begin
        r_rel <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign w_push      = r_frame_vld && (r_frame_code != 8'hE0) && (r_frame_code != 8'hF0);
  assign w_push_data = {r_ext, r_rel, r_frame_code};

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == (AW+1)'(0));
  assign w_full  = (w_count == (AW+1)'(DEPTH));
  assign w_pop   = rd_en & ~w_empty;
  assign w_wr    = w_push & (~w_full | w_pop);

  // fifo pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= (AW+1)'(0);
      r_rptr     <= (AW+1)'(0);
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // fifo storage, no reset needed: reads are masked while empty
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_push_data;
  end

  assign rd_valid = ~w_empty;
  assign count    = w_count;
  assign overflow = r_overflow;
  assign rd_data  = w_empty ? 10'd0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Scoreboard bench for ps2_scancode_fifo: PS/2 frames are driven on the pins,
// a key-event model queues the expected entries, and a monitor checks every pop.
`timescale 1ns/1ps
module tb_ps2_scancode_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 200;
  localparam int unsigned HP    = 8;   // clk cycles per PS/2 clock half period
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ps2_clk = 1'b1;
  logic                   data = 1'b1;
  logic                   rd_en;
  logic [9:0]             rd_data;
  logic                   rd_valid;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   parity_err;

  ps2_scancode_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .data(data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] exp_q[$];
  bit m_ext = 0, m_rel = 0, exp_ovf = 0, exp_perr = 0;
  bit rd_phase = 0;
  logic r_rand_en = 1'b0;
  logic r_pulse_en = 1'b0;
  assign rd_en = r_rand_en | r_pulse_en;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // key-event model: what the keyboard register should eventually show
  task automatic model_frame(input logic [7:0] code, input bit bad_par, input bit stop, input bit pop_same);
    logic [9:0] ev;
    bit accept;
    accept = stop && !(PAR_EN && bad_par);
    if (PAR_EN && bad_par) exp_perr = 1;
    if (accept) begin
      if (code == 8'hE0) m_ext = 1;
      else if (code == 8'hF0) m_rel = 1;
      else begin
        ev = {m_ext, m_rel, code};
        m_ext = 0;
        m_rel = 0;
        if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(ev);
        else exp_ovf = 1;
      end
    end
  endtask

  task automatic ps2_bit(input logic b);
    data = b;
    wait_cycles(HP);
    ps2_clk = 1'b0;
    wait_cycles(HP);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain, 1: check write latency, 2: pop exactly in the write cycle
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop, input int mode);
    logic [10:0] fb;
    logic par;
    par = bad_par ? (^code) : ~(^code);
    fb  = {stop, par, code, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(fb[i]);
    data = stop;
    wait_cycles(HP);
    model_frame(code, bad_par, stop, mode == 2);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      wait_cycles(3);
      check("lat_valid_n1", int'(rd_valid), 0);
      check("lat_count_n1", int'(count), 0);
      tick();
      check("lat_valid_n2", int'(rd_valid), 1);
      check("lat_count_n2", int'(count), 1);
      wait_cycles(HP - 4);
    end else if (mode == 2) begin
      wait_cycles(3);
      r_pulse_en = 1'b1;
      tick();
      r_pulse_en = 1'b0;
      wait_cycles(HP - 4);
    end else begin
      wait_cycles(HP);
    end
    ps2_clk = 1'b1;
    data = 1'b1;
    wait_cycles(HP);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    data = 1'b1;
  endtask

  task automatic drain();
    int n;
    rd_phase = 1;
    n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < 2000) begin
      tick();
      n++;
    end
    rd_phase = 0;
    wait_cycles(2);
    check("drain_valid", int'(rd_valid), 0);
    check("drain_model_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(rd_valid), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_data"}, int'(rd_data), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_perr"}, int'(parity_err), 0);
  endtask

  // random pop requests while a read phase is open
  initial begin
    forever begin
      @(posedge clk);
      #1;
      r_rand_en = rd_phase && ($urandom_range(0, 1) == 1);
    end
  end

  // monitor: every accepted pop is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got %0h, expected no entry at %0t", rd_data, $time);
      end else begin
        check("pop_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] code;
    int r;
    wait_cycles(4);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    wait_cycles(5);

    // single make code with latency check
    send_frame(8'h1C, 0, 1, 1);
    drain();

    // extended release then plain make
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h75, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    drain();

    // inverted parity
    send_frame(8'h1C, 1, 1, 0);
    drain();
    check("parity_err", int'(parity_err), int'(exp_perr));

    // fill past capacity, then push+pop while full
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h10 + i), 0, 1, 0);
    check("full_count", int'(count), DEPTH);
    check("full_ovf", int'(overflow), int'(exp_ovf));
    send_frame(8'h55, 0, 1, 2);
    check("full_pushpop_count", int'(count), DEPTH);
    drain();
    check("ovf_sticky", int'(overflow), int'(exp_ovf));

    // abandoned partial frame
    send_partial(5);
    wait_cycles(TMO + 20);
    send_frame(8'h29, 0, 1, 0);
    drain();

    // random traffic with concurrent reads
    rd_phase = 1;
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 3));
      code = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 15));
      send_frame(code, r == 0, r != 1, 0);
    end
    drain();
    check("rand_perr", int'(parity_err), int'(exp_perr));
    check("rand_ovf", int'(overflow), int'(exp_ovf));

    // reset with entry queued, prefix pending and frame in flight
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_partial(6);
    rst_n = 1'b0;
    exp_q.delete();
    m_ext = 0; m_rel = 0; exp_ovf = 0; exp_perr = 0;
    wait_cycles(3);
    check_reset_outputs("rst1");
    ps2_clk = 1'b1;
    data = 1'b1;
    rst_n = 1'b1;
    wait_cycles(5);
    send_frame(8'h1C, 0, 1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
